// File: rtl/frog_pkg.sv
// Shared types and widths for the frog tracker: game state, decoded move
// and the score/lives counter widths.
package frog_pkg;

  localparam int SCORE_W = 8;
  localparam int LIVES_W = 3;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    DEAD = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4
  } move_t;

endpackage

// File: rtl/frog_tracker_move_arb.sv
// Picks one key pulse (U > D > L > R) and works out where the frog would land,
// applying the grid-edge wrap or clamp rules.
module frog_move_arb
  import frog_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 0,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          u,
  input  logic          d,
  input  logic          l,
  input  logic          r,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output move_t         move,
  output logic [RW-1:0] next_row,
  output logic [CW-1:0] next_col
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  always_comb begin
    move     = MV_NONE;
    next_row = row;
    next_col = col;
    if (u) begin
      move = MV_UP;
      if (row != '0) next_row = row - 1'b1;
    end else if (d) begin
      move = MV_DOWN;
      if (row != LAST_ROW) next_row = row + 1'b1;
    end else if (l) begin
      move = MV_LEFT;
      if (col != '0)     next_col = col - 1'b1;
      else if (WRAP != 0) next_col = LAST_COL;
    end else if (r) begin
      move = MV_RIGHT;
      if (col != LAST_COL) next_col = col + 1'b1;
      else if (WRAP != 0)  next_col = '0;
    end
  end

endmodule

// File: rtl/frog_tracker.sv
// Frog position, lives, respawn delay, win detection and score for the LED
// grid game; drives the one-hot green pixel plane.
module frog_tracker
  import frog_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int START_ROW   = 15,
  parameter int START_COL   = 7,
  parameter int WRAP        = 0,
  parameter int LIVES       = 3,
  parameter int RESPAWN_CYC = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                       Clock,
  input  logic                       reset,
  input  logic                       L,
  input  logic                       R,
  input  logic                       U,
  input  logic                       D,
  input  logic                       lost,
  output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
  output logic [RW-1:0]              row,
  output logic [CW-1:0]              col,
  output logic [LIVES_W-1:0]         lives_left,
  output logic [SCORE_W-1:0]         score,
  output logic                       win,
  output logic                       game_over
);

  localparam int NW = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
  localparam logic [RW-1:0]      START_R  = RW'(START_ROW);
  localparam logic [CW-1:0]      START_C  = CW'(START_COL);
  localparam logic [LIVES_W-1:0] LIVES_I  = LIVES_W'(LIVES);
  localparam logic [NW-1:0]      LAST_CNT = NW'(RESPAWN_CYC - 1);

  state_t        state;
  logic [NW-1:0] cnt;
  move_t         move;
  logic [RW-1:0] nrow;
  logic [CW-1:0] ncol;

  frog_move_arb #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_arb (
    .u        (U),
    .d        (D),
    .l        (L),
    .r        (R),
    .row      (row),
    .col      (col),
    .move     (move),
    .next_row (nrow),
    .next_col (ncol)
  );

  // win is a one-cycle pulse; while it is high the frog sits on row 0 and the
  // next edge either banks the crossing or, if hit, takes the collision instead.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state      <= PLAY;
      row        <= START_R;
      col        <= START_C;
      lives_left <= LIVES_I;
      score      <= '0;
      win        <= 1'b0;
      game_over  <= 1'b0;
      cnt        <= '0;
    end else begin
      win <= 1'b0;
      case (state)
        PLAY: begin
          if (lost) begin
            if (lives_left <= LIVES_W'(1)) begin
              lives_left <= '0;
              state      <= OVER;
              game_over  <= 1'b1;
            end else begin
              lives_left <= lives_left - 1'b1;
              state      <= DEAD;
              cnt        <= '0;
            end
          end else if (win) begin
            if (score != '1) score <= score + 1'b1;
            row <= START_R;
            col <= START_C;
          end else if (move != MV_NONE) begin
            row <= nrow;
            col <= ncol;
            win <= (move == MV_UP) && (nrow == '0) && (row != '0);
          end
        end
        DEAD: begin
          if (cnt == LAST_CNT) begin
            state <= PLAY;
            row   <= START_R;
            col   <= START_C;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OVER: ;
        default: state <= PLAY;
      endcase
    end
  end

  always_comb begin
    GrnPixels = '0;
    if (state == PLAY) GrnPixels[row][col] = 1'b1;
  end

endmodule

// File: tb/tb_frog_tracker.sv
// Bench for frog_tracker: directed scenarios plus randomized play compared
// against a rule-level game model, with a clamp and a wrap instance side by side.
module tb_frog_tracker;

  logic Clock = 1'b0;
  logic reset = 1'b0;
  logic L = 1'b0, R = 1'b0, U = 1'b0, D = 1'b0, lost = 1'b0;

  logic [15:0][15:0] gp [2];
  logic [3:0]        rw [2];
  logic [3:0]        cl [2];
  logic [2:0]        lv [2];
  logic [7:0]        sc [2];
  logic              wn [2];
  logic              go [2];

  int checks = 0;
  int passes = 0;

  // model: phase 0=playing 1=dead 2=over; dead_left = dead cycles still to show
  int m_row[2], m_col[2], m_lives[2], m_score[2], m_win[2], m_phase[2], m_dead[2];

  always #5 Clock = ~Clock;

  frog_tracker #(.WRAP(0)) dut_clamp (
    .Clock(Clock), .reset(reset), .L(L), .R(R), .U(U), .D(D), .lost(lost),
    .GrnPixels(gp[0]), .row(rw[0]), .col(cl[0]), .lives_left(lv[0]),
    .score(sc[0]), .win(wn[0]), .game_over(go[0])
  );

  frog_tracker #(.WRAP(1)) dut_wrap (
    .Clock(Clock), .reset(reset), .L(L), .R(R), .U(U), .D(D), .lost(lost),
    .GrnPixels(gp[1]), .row(rw[1]), .col(cl[1]), .lives_left(lv[1]),
    .score(sc[1]), .win(wn[1]), .game_over(go[1])
  );

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_row[w] = 15; m_col[w] = 7; m_lives[w] = 3; m_score[w] = 0;
      m_win[w] = 0; m_phase[w] = 0; m_dead[w] = 0;
    end
  endtask

  task automatic model_step(input bit u, input bit d, input bit l, input bit r, input bit ls);
    for (int w = 0; w < 2; w++) begin
      if (m_phase[w] == 0) begin
        if (ls) begin
          m_win[w] = 0;
          if (m_lives[w] > 0) m_lives[w] = m_lives[w] - 1;
          if (m_lives[w] == 0) m_phase[w] = 2;
          else begin m_phase[w] = 1; m_dead[w] = 4; end
        end else if (m_win[w] != 0) begin
          m_win[w] = 0;
          m_score[w] = (m_score[w] >= 255) ? 255 : m_score[w] + 1;
          m_row[w] = 15; m_col[w] = 7;
        end else begin
          m_win[w] = 0;
          if (u) begin
            if (m_row[w] > 0) m_row[w] = m_row[w] - 1;
            if (m_row[w] == 0) m_win[w] = 1;
          end else if (d) begin
            if (m_row[w] < 15) m_row[w] = m_row[w] + 1;
          end else if (l) begin
            if (m_col[w] > 0) m_col[w] = m_col[w] - 1;
            else if (w == 1) m_col[w] = 15;
          end else if (r) begin
            if (m_col[w] < 15) m_col[w] = m_col[w] + 1;
            else if (w == 1) m_col[w] = 0;
          end
        end
      end else if (m_phase[w] == 1) begin
        m_win[w] = 0;
        m_dead[w] = m_dead[w] - 1;
        if (m_dead[w] == 0) begin
          m_phase[w] = 0; m_row[w] = 15; m_col[w] = 7;
        end
      end
    end
  endtask

  task automatic cycle(input bit u, input bit d, input bit l, input bit r, input bit ls);
    U = u; D = d; L = l; R = r; lost = ls;
    @(posedge Clock);
    model_step(u, d, l, r, ls);
    #1;
    U = 1'b0; D = 1'b0; L = 1'b0; R = 1'b0; lost = 1'b0;
  endtask

  task automatic do_reset();
    U = 1'b0; D = 1'b0; L = 1'b0; R = 1'b0; lost = 1'b0;
    reset = 1'b0;
    model_reset();
    #2;
    @(negedge Clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int w = 0; w < 2; w++) begin
      checks++; if (rw[w] !== 4'd15 || cl[w] !== 4'd7)
        $display("FAIL reset_pos[%0d]: got (%0d,%0d) want (15,7)", w, rw[w], cl[w]); else passes++;
      checks++; if (lv[w] !== 3'd3 || sc[w] !== 8'd0 || wn[w] !== 1'b0 || go[w] !== 1'b0)
        $display("FAIL reset_regs[%0d]: got lives=%0d score=%0d win=%0b over=%0b want 3/0/0/0",
                 w, lv[w], sc[w], wn[w], go[w]); else passes++;
      checks++; if (gp[w] !== (256'd1 << (15*16 + 7)))
        $display("FAIL reset_pix[%0d]: got %h want bit [15][7] only", w, gp[w]); else passes++;
    end
  endtask

  task automatic test_up_win();
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      cycle(1, 0, 0, 0, 0);
      checks++; if (rw[0] !== 4'(15 - i) || wn[0] !== 1'b0)
        $display("FAIL up_step%0d: got row=%0d win=%0b want row=%0d win=0", i, rw[0], wn[0], 15 - i); else passes++;
    end
    cycle(1, 0, 0, 0, 0);
    checks++; if (rw[0] !== 4'd0 || wn[0] !== 1'b1 || gp[0][0][7] !== 1'b1)
      $display("FAIL win_pulse: got row=%0d win=%0b pix=%0b want 0/1/1", rw[0], wn[0], gp[0][0][7]); else passes++;
    cycle(1, 0, 1, 0, 0);
    checks++; if (rw[0] !== 4'd15 || cl[0] !== 4'd7 || sc[0] !== 8'd1 || wn[0] !== 1'b0)
      $display("FAIL after_win: got (%0d,%0d) score=%0d win=%0b want (15,7) 1 0", rw[0], cl[0], sc[0], wn[0]); else passes++;
  endtask

  task automatic test_left_edge();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 0, 0);
      checks++; if (cl[0] !== 4'((i > 7) ? 0 : 7 - i))
        $display("FAIL clamp_col%0d: got %0d want %0d", i, cl[0], (i > 7) ? 0 : 7 - i); else passes++;
      checks++; if (cl[1] !== 4'((i == 8) ? 15 : 7 - i))
        $display("FAIL wrap_col%0d: got %0d want %0d", i, cl[1], (i == 8) ? 15 : 7 - i); else passes++;
    end
    checks++; if (gp[0][15][0] !== 1'b1 || gp[1][15][15] !== 1'b1)
      $display("FAIL edge_pix: got clamp[15][0]=%0b wrap[15][15]=%0b want 1/1", gp[0][15][0], gp[1][15][15]); else passes++;
    cycle(0, 0, 0, 1, 0);
    checks++; if (cl[1] !== 4'd0)
      $display("FAIL wrap_right: got %0d want 0", cl[1]); else passes++;
  endtask

  task automatic test_priority();
    do_reset();
    cycle(1, 0, 1, 0, 0);
    checks++; if (rw[0] !== 4'd14 || cl[0] !== 4'd7)
      $display("FAIL prio_ul: got (%0d,%0d) want (14,7)", rw[0], cl[0]); else passes++;
    cycle(0, 1, 0, 1, 0);
    checks++; if (rw[0] !== 4'd15 || cl[0] !== 4'd7)
      $display("FAIL prio_dr: got (%0d,%0d) want (15,7)", rw[0], cl[0]); else passes++;
  endtask

  task automatic test_lost_respawn();
    do_reset();
    repeat (3) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (gp[0] !== '0 || lv[0] !== 3'd2)
        $display("FAIL dead_cyc%0d: got pix_nonzero=%0b lives=%0d want 0/2", i, gp[0] != '0, lv[0]); else passes++;
      cycle(1, 0, 0, 0, (i == 1));
    end
    checks++; if (rw[0] !== 4'd15 || cl[0] !== 4'd7 || gp[0][15][7] !== 1'b1 || lv[0] !== 3'd2)
      $display("FAIL respawn: got (%0d,%0d) pix=%0b lives=%0d want (15,7) 1 2", rw[0], cl[0], gp[0][15][7], lv[0]); else passes++;
  endtask

  task automatic test_lost_with_move();
    do_reset();
    cycle(1, 0, 0, 0, 1);
    checks++; if (gp[0] !== '0 || lv[0] !== 3'd2 || go[0] !== 1'b0)
      $display("FAIL lost_move: got pix_nonzero=%0b lives=%0d over=%0b want 0/2/0", gp[0] != '0, lv[0], go[0]); else passes++;
  endtask

  task automatic test_lost_in_win();
    do_reset();
    repeat (15) cycle(1, 0, 0, 0, 0);
    checks++; if (wn[0] !== 1'b1)
      $display("FAIL lwin_pulse: got %0b want 1", wn[0]); else passes++;
    cycle(0, 0, 0, 0, 1);
    checks++; if (sc[0] !== 8'd0 || lv[0] !== 3'd2 || gp[0] !== '0 || wn[0] !== 1'b0)
      $display("FAIL lost_in_win: got score=%0d lives=%0d pix_nonzero=%0b win=%0b want 0/2/0/0",
               sc[0], lv[0], gp[0] != '0, wn[0]); else passes++;
  endtask

  task automatic test_game_over();
    do_reset();
    repeat (3) begin
      cycle(0, 0, 0, 0, 1);
      repeat (4) cycle(0, 0, 0, 0, 0);
    end
    checks++; if (go[0] !== 1'b1 || gp[0] !== '0 || lv[0] !== 3'd0)
      $display("FAIL over: got over=%0b pix_nonzero=%0b lives=%0d want 1/0/0", go[0], gp[0] != '0, lv[0]); else passes++;
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    checks++; if (go[0] !== 1'b1 || gp[0] !== '0 || lv[0] !== 3'd0)
      $display("FAIL over_hold: got over=%0b pix_nonzero=%0b lives=%0d want 1/0/0", go[0], gp[0] != '0, lv[0]); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (lv[0] !== 3'd3 || rw[0] !== 4'd15 || cl[0] !== 4'd7 || gp[0][15][7] !== 1'b1 || go[0] !== 1'b0)
      $display("FAIL async_reset: got lives=%0d (%0d,%0d) pix=%0b over=%0b want 3 (15,7) 1 0",
               lv[0], rw[0], cl[0], gp[0][15][7], go[0]); else passes++;
    model_reset();
    @(negedge Clock);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0][15:0] eg;
    bit u, d, l, r, ls;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      u  = ($urandom_range(2) == 0);
      d  = ($urandom_range(4) == 0);
      l  = ($urandom_range(1) == 1);
      r  = ($urandom_range(1) == 1);
      ls = ($urandom_range(13) == 0);
      cycle(u, d, l, r, ls);
      for (int w = 0; w < 2; w++) begin
        eg = '0;
        if (m_phase[w] == 0) eg[m_row[w]][m_col[w]] = 1'b1;
        checks++; if (gp[w] !== eg)
          $display("FAIL rnd_pix[%0d] cyc%0d: got %h want %h", w, i, gp[w], eg); else passes++;
        if (m_phase[w] == 0) begin
          checks++; if (rw[w] !== 4'(m_row[w]) || cl[w] !== 4'(m_col[w]))
            $display("FAIL rnd_pos[%0d] cyc%0d: got (%0d,%0d) want (%0d,%0d)", w, i, rw[w], cl[w], m_row[w], m_col[w]); else passes++;
        end
        checks++; if (lv[w] !== 3'(m_lives[w]) || sc[w] !== 8'(m_score[w]) ||
                      wn[w] !== 1'(m_win[w]) || go[w] !== (m_phase[w] == 2))
          $display("FAIL rnd_regs[%0d] cyc%0d: got lives=%0d score=%0d win=%0b over=%0b want %0d/%0d/%0d/%0b",
                   w, i, lv[w], sc[w], wn[w], go[w], m_lives[w], m_score[w], m_win[w], m_phase[w] == 2); else passes++;
      end
      if (m_phase[0] == 2 && m_phase[1] == 2) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_up_win();
    test_left_edge();
    test_priority();
    test_lost_respawn();
    test_lost_with_move();
    test_lost_in_win();
    test_game_over();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frog_tracker.md
Name: frog_tracker

Overview:
Parametrised successor to the per-cell frog lighting array. It holds the frog as a registered row/column coordinate on a ROWS x COLS LED grid instead of one flip-flop per pixel. It adds edge wrap/clamp modes, a lives counter, a respawn delay, win detection and a score counter. The block sits between the debounced, edge-detected key pulses and the LED driver's GrnPixels plane; the car-lane logic drives `lost`.

Parameters:
ROWS, 16, grid height; row 0 is the goal (top) row
COLS, 16, grid width
START_ROW, 15, respawn row
START_COL, 7, respawn column
WRAP, 0, 1 = horizontal wrap-around at column edges; 0 = clamp
LIVES, 3, lives loaded at reset (1..7)
RESPAWN_CYC, 4, cycles spent in DEAD before the frog reappears (>=1)

Ports:
Clock  in  1  system clock, all logic on the rising edge
reset  in  1  asynchronous, active-low (0 = reset)
L  in  1  one-cycle pulse, move left (col-1)
R  in  1  one-cycle pulse, move right (col+1)
U  in  1  one-cycle pulse, move up (row-1)
D  in  1  one-cycle pulse, move down (row+1)
lost  in  1  collision with the frog's current cell, sampled every cycle
GrnPixels  out  [ROWS-1:0][COLS-1:0]  one-hot frog pixel, or all zero when hidden
row  out  $clog2(ROWS)  current frog row
col  out  $clog2(COLS)  current frog column
lives_left  out  3  remaining lives
score  out  8  completed crossings, saturates at 255
win  out  1  one-cycle pulse when the frog reaches row 0
game_over  out  1  high while in the OVER state

Behaviour:
- Reset values (reset=0, asynchronous): state=PLAY, row=START_ROW, col=START_COL, lives_left=LIVES, score=0, win=0, game_over=0, respawn counter=0.
- GrnPixels is combinational from the registers: exactly bit [row][col] is set in PLAY; all bits are 0 in DEAD and OVER.
- States:
  - PLAY:
    - lost=1: lives_left-1. If the result is 0, go to OVER; otherwise go to DEAD and clear the counter.
    - else a move is taken: at most one move per cycle, priority U > D > L > R, applied on the next edge (latency 1).
  - DEAD: the counter increments each cycle. When it reaches RESPAWN_CYC-1, reload row/col to START and go to PLAY. lost and moves are ignored.
  - OVER: all inputs ignored; only reset leaves this state.
- Edge rules:
  - U at row 0 cannot occur, because reaching row 0 triggers a win.
  - D at row ROWS-1 is ignored.
  - L at col 0: WRAP=1 moves to COLS-1; WRAP=0 ignores it.
  - R at col COLS-1: WRAP=1 moves to 0; WRAP=0 ignores it.
- Win:
  - When a U move makes the row 0, assert `win` for one cycle together with the new position.
  - On the following edge, score+1 (saturating at 255), row/col reload to START, and state stays PLAY.
  - Moves arriving in the win cycle are ignored.
- Simultaneous events:
  - lost together with any move: lost wins and the move is dropped.
  - lost in the win cycle: the collision is counted (lives-1, go to DEAD), score is unchanged, and `win` still pulses because it is registered from the previous edge.
- lives_left never underflows. game_over equals (state==OVER).
- A reset mid-DEAD or mid-OVER restores all reset values immediately.

Decomposition:
- Shared package frog_pkg:
  - state enum (PLAY, DEAD, OVER)
  - move enum (NONE, UP, DOWN, LEFT, RIGHT)
  - SCORE_W=8, LIVES_W=3 constants
- One natural sub-module, frog_move_arb: combinational priority encoder of U/D/L/R to the move enum, plus next-coordinate computation with the WRAP/clamp rules.
- Counters and the FSM live in frog_tracker.

Test Plan:
1. Reset, then 14 U pulses at default parameters -> row steps 15→1; the 15th U gives row=0 and win=1 for one cycle, then row=15, col=7, score=1.
2. WRAP=0, 8 L pulses from col 7 -> col stops at 0, GrnPixels[15][0]=1. Then with WRAP=1, one further L from col 0 -> col=15.
3. U and L asserted in the same cycle from (15,7) -> position becomes (14,7); col is unchanged.
4. lost pulse at (12,7) -> GrnPixels all zero for 4 cycles, lives_left=2, then frog at (15,7).
5. lost together with U in the same cycle -> no move taken, lives-1, state DEAD.
6. 3 losses at LIVES=3 -> game_over=1, GrnPixels=0, U/lost ignored. Assert reset=0 mid-OVER -> lives_left=3, frog at (15,7) without waiting for a clock edge.
